// File: rtl/seq_mult_signed_pkg.sv
// Shared types and helpers for the signed sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, DONE} mult_state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_signed_if.sv
// Control/data bundle between the input synchronisers, the multiplier and the display drivers.
interface seq_mult_signed_if #(parameter int WIDTH = 8);
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Xval;
  logic             Busy;
  logic             Done;

  modport master (output Run, ClearA_LoadB, Din,
                  input  Aval, Bval, Xval, Busy, Done);
  modport slave  (input  Run, ClearA_LoadB, Din,
                  output Aval, Bval, Xval, Busy, Done);
endinterface

// File: rtl/seq_mult_signed_addsub.sv
// Combinational WIDTH+1-bit sign-extending adder/subtractor (a +/- b).
module addsub_ext #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;

  assign w_a = {a[WIDTH-1], a};
  // Two's-complement subtract: invert and inject the +1 as carry-in.
  assign w_b = {b[WIDTH-1], b} ^ {(WIDTH+1){sub}};
  assign sum = w_a + w_b + {{WIDTH{1'b0}}, sub};
endmodule

// File: rtl/seq_mult_signed.sv
// Signed shift-add multiplier: counter-driven FSM plus A/B/X/S datapath, optional zero-bit skip.
module seq_mult_signed
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  seq_mult_signed_if.slave  bus
);
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_x;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;
  logic             w_last;
  logic             w_busy, w_done;

  assign w_last = (r_cnt == LAST);

  // The final multiplier bit carries negative weight, hence the subtract.
  addsub_ext #(.WIDTH(WIDTH)) u_addsub (
    .a   (r_a),
    .b   (r_s),
    .sub (w_last),
    .sum (w_sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!bus.ClearA_LoadB && bus.Run) w_next = CLEAR;
      CLEAR:   w_next = (SKIP_ZERO && !r_b[0]) ? SHIFT : ADD;
      ADD:     w_next = SHIFT;
      // r_b[1] is the multiplier bit that lands in B[0] after this shift.
      SHIFT:   if (w_last)                    w_next = DONE;
               else if (SKIP_ZERO && !r_b[1]) w_next = SHIFT;
               else                           w_next = ADD;
      DONE:    if (!bus.Run) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == CLEAR) || (r_state == ADD) || (r_state == SHIFT);
    w_done = (r_state == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_x   <= 1'b0;
      r_s   <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.ClearA_LoadB) begin
          r_a <= '0;
          r_x <= 1'b0;
          r_b <= bus.Din;
        end
        CLEAR: begin
          r_s   <= bus.Din;
          r_a   <= '0;
          r_x   <= 1'b0;
          r_cnt <= '0;
        end
        ADD: if (r_b[0]) {r_x, r_a} <= w_sum;
        SHIFT: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
          if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.Aval = r_a;
  assign bus.Bval = r_b;
  assign bus.Xval = r_x;
  assign bus.Busy = w_busy;
  assign bus.Done = w_done;
endmodule

// File: tb/tb_seq_mult_signed.sv
// Bench for seq_mult_signed: four configurations checked every cycle against a product-level model.
module tb_seq_mult_signed;
  localparam int ND = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Configurations: 0 = W8, 1 = W8 skip-zero, 2 = W4, 3 = W16
  function automatic int dw(input int k);
    case (k)
      2:       return 4;
      3:       return 16;
      default: return 8;
    endcase
  endfunction
  function automatic bit dsk(input int k);
    return k == 1;
  endfunction
  function automatic longint msk(input int k);
    return (64'sd1 <<< dw(k)) - 64'sd1;
  endfunction
  function automatic longint sx(input logic [15:0] v, input int w);
    longint r;
    r = longint'(v) & ((64'sd1 <<< w) - 64'sd1);
    if (v[w-1]) r = r - (64'sd1 <<< w);
    return r;
  endfunction

  logic        run_a [ND];
  logic        clb_a [ND];
  logic [15:0] din_a [ND];
  logic [15:0] a_o   [ND];
  logic [15:0] b_o   [ND];
  logic        x_o   [ND];
  logic        busy_o[ND];
  logic        done_o[ND];

  seq_mult_signed_if #(.WIDTH(8))  if0 ();
  seq_mult_signed_if #(.WIDTH(8))  if1 ();
  seq_mult_signed_if #(.WIDTH(4))  if2 ();
  seq_mult_signed_if #(.WIDTH(16)) if3 ();

  assign if0.Run = run_a[0]; assign if0.ClearA_LoadB = clb_a[0]; assign if0.Din = din_a[0][7:0];
  assign if1.Run = run_a[1]; assign if1.ClearA_LoadB = clb_a[1]; assign if1.Din = din_a[1][7:0];
  assign if2.Run = run_a[2]; assign if2.ClearA_LoadB = clb_a[2]; assign if2.Din = din_a[2][3:0];
  assign if3.Run = run_a[3]; assign if3.ClearA_LoadB = clb_a[3]; assign if3.Din = din_a[3];

  assign a_o[0] = {8'h00, if0.Aval};  assign b_o[0] = {8'h00, if0.Bval};
  assign a_o[1] = {8'h00, if1.Aval};  assign b_o[1] = {8'h00, if1.Bval};
  assign a_o[2] = {12'h000, if2.Aval}; assign b_o[2] = {12'h000, if2.Bval};
  assign a_o[3] = if3.Aval;           assign b_o[3] = if3.Bval;
  assign x_o[0] = if0.Xval; assign busy_o[0] = if0.Busy; assign done_o[0] = if0.Done;
  assign x_o[1] = if1.Xval; assign busy_o[1] = if1.Busy; assign done_o[1] = if1.Done;
  assign x_o[2] = if2.Xval; assign busy_o[2] = if2.Busy; assign done_o[2] = if2.Done;
  assign x_o[3] = if3.Xval; assign busy_o[3] = if3.Busy; assign done_o[3] = if3.Done;

  seq_mult_signed #(.WIDTH(8),  .SKIP_ZERO(1'b0)) u0 (.Clk(Clk), .Reset(Reset), .bus(if0));
  seq_mult_signed #(.WIDTH(8),  .SKIP_ZERO(1'b1)) u1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  seq_mult_signed #(.WIDTH(4),  .SKIP_ZERO(1'b0)) u2 (.Clk(Clk), .Reset(Reset), .bus(if2));
  seq_mult_signed #(.WIDTH(16), .SKIP_ZERO(1'b0)) u3 (.Clk(Clk), .Reset(Reset), .bus(if3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Product-level model: 0 idle, 1 busy (count of remaining busy cycles), 2 done
  int          ms  [ND] = '{default: 0};
  int          left[ND] = '{default: 0};
  longint      pend[ND] = '{default: 0};
  logic [15:0] mA  [ND] = '{default: 16'h0};
  logic [15:0] mB  [ND] = '{default: 16'h0};

  always @(posedge Clk or posedge Reset) begin
    for (int k = 0; k < ND; k++) begin
      if (Reset) begin
        ms[k] <= 0; left[k] <= 0; mA[k] <= '0; mB[k] <= '0;
      end else begin
        case (ms[k])
          0: if (clb_a[k]) begin
            mA[k] <= '0;
            mB[k] <= 16'(longint'(din_a[k]) & msk(k));
          end else if (run_a[k]) begin
            pend[k] <= sx(din_a[k], dw(k)) * sx(mB[k], dw(k));
            left[k] <= dsk(k) ? 1 + dw(k) + $countones(mB[k]) : 1 + 2 * dw(k);
            ms[k]   <= 1;
          end
          1: begin
            left[k] <= left[k] - 1;
            if (left[k] == 1) begin
              ms[k] <= 2;
              mA[k] <= 16'((pend[k] >>> dw(k)) & msk(k));
              mB[k] <= 16'(pend[k] & msk(k));
            end
          end
          default: if (!run_a[k]) ms[k] <= 0;
        endcase
      end
    end
  end

  // Status every cycle; registers whenever the model says they are settled.
  always @(negedge Clk) begin
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("busy[%0d]", k), 64'(busy_o[k]), 64'(ms[k] == 1));
      chk($sformatf("done[%0d]", k), 64'(done_o[k]), 64'(ms[k] == 2));
      if (ms[k] != 1) begin
        chk($sformatf("A[%0d]", k), 64'(a_o[k]), 64'(mA[k]));
        chk($sformatf("B[%0d]", k), 64'(b_o[k]), 64'(mB[k]));
        chk($sformatf("X[%0d]", k), 64'(x_o[k]), 64'(mA[k][dw(k)-1]));
      end
    end
  end

  task automatic mult(input int k, input bit load, input logic [15:0] b, input logic [15:0] d,
                      input int hold, output int lat, output int nbusy,
                      output logic [63:0] ab, output logic x);
    if (load) begin
      clb_a[k] = 1'b1;
      din_a[k] = b;
      run_a[k] = 1'($urandom_range(0, 1));
      @(negedge Clk);
      clb_a[k] = 1'b0;
    end
    din_a[k] = d;
    run_a[k] = 1'b1;
    lat = 0; nbusy = 0; ab = '0; x = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clk);
      if (busy_o[k]) nbusy++;
      if (done_o[k]) begin
        lat = n;
        break;
      end
      // Din is sampled one cycle after Run; after that both it and ClearA_LoadB are don't-care.
      if (n >= 2) begin
        clb_a[k] = 1'($urandom_range(0, 1));
        din_a[k] = 16'($urandom);
      end
    end
    clb_a[k] = 1'b0;
    if (lat == 0) chk($sformatf("done timeout[%0d]", k), 64'(lat), 64'd1);
    ab = (64'(a_o[k]) << dw(k)) | 64'(b_o[k]);
    x  = x_o[k];
    repeat (hold) @(negedge Clk);
    run_a[k] = 1'b0;
    @(negedge Clk);
  endtask

  int          lat, nb;
  logic [63:0] ab;
  logic        x;

  initial begin
    for (int k = 0; k < ND; k++) begin
      run_a[k] = 1'b0; clb_a[k] = 1'b0; din_a[k] = '0;
    end
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("reset A", 64'(a_o[0]), 64'h0);
    chk("reset busy/done", {62'h0, busy_o[0], done_o[0]}, 64'h0);
    Reset = 1'b0;
    @(negedge Clk);

    mult(0, 1'b1, 16'hFD, 16'h07, 2, lat, nb, ab, x);
    chk("-3*7 latency", 64'(lat), 64'd18);
    chk("-3*7 product", ab, 64'hFFEB);
    chk("-3*7 X", 64'(x), 64'd1);

    mult(0, 1'b1, 16'h80, 16'h80, 0, lat, nb, ab, x);
    chk("-128*-128 product", ab, 64'h4000);
    chk("-128*-128 X", 64'(x), 64'd0);
    chk("-128*-128 busy cycles", 64'(nb), 64'd17);

    mult(0, 1'b1, 16'h01, 16'h02, 0, lat, nb, ab, x);
    chk("1*2 product", ab, 64'h0002);
    mult(0, 1'b0, 16'h00, 16'h03, 4, lat, nb, ab, x);
    chk("consecutive product", ab, 64'h0006);

    mult(1, 1'b1, 16'h01, 16'h7F, 0, lat, nb, ab, x);
    chk("skip 1*127 latency", 64'(lat), 64'd11);
    chk("skip 1*127 product", ab, 64'h007F);
    mult(1, 1'b1, 16'h00, 16'h7F, 0, lat, nb, ab, x);
    chk("skip 0*127 latency", 64'(lat), 64'd10);
    chk("skip 0*127 product", ab, 64'h0000);

    // Abort during the fourth SHIFT
    clb_a[0] = 1'b1; din_a[0] = 16'h33;
    @(negedge Clk);
    clb_a[0] = 1'b0; din_a[0] = 16'h5A; run_a[0] = 1'b1;
    repeat (9) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort A/B/X", {a_o[0], b_o[0], 15'h0, x_o[0]}, 64'h0);
    chk("abort busy/done", {62'h0, busy_o[0], done_o[0]}, 64'h0);
    run_a[0] = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    mult(0, 1'b1, 16'h05, 16'hFE, 0, lat, nb, ab, x);
    chk("post-abort product", ab, 64'hFFF6);
    chk("post-abort latency", 64'(lat), 64'd18);

    mult(2, 1'b1, 16'h8, 16'h8, 0, lat, nb, ab, x);
    chk("W4 product", ab, 64'h40);
    chk("W4 latency", 64'(lat), 64'd10);
    mult(3, 1'b1, 16'h8000, 16'h7FFF, 0, lat, nb, ab, x);
    chk("W16 product", ab, 64'hC0008000);
    chk("W16 latency", 64'(lat), 64'd34);

    for (int it = 0; it < 80; it++) begin
      int k;
      k = $urandom_range(0, ND - 1);
      mult(k, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           $urandom_range(0, 3), lat, nb, ab, x);
    end

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
